// File: rtl/acc_req_scheduler.sv
// Shares one accelerator port between NumReq requesters.
// Round-robin grant, per-requester credits, ID-based response routing.
module acc_req_scheduler #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned AddrWidth      = 4,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxWidth =
    (NumReq > 1) ? $clog2(NumReq) : 1,
  localparam int unsigned ExtIdWidth = IdWidth + IdxWidth,
  localparam int unsigned CntWidth   = $clog2(MaxOutstanding + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NumReq-1:0]             req_valid_i,
  output logic [NumReq-1:0]             req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
  input  logic [NumReq*IdWidth-1:0]     req_id_i,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  output logic                          acc_req_valid_o,
  input  logic                          acc_req_ready_i,
  output logic [AddrWidth-1:0]          acc_req_addr_o,
  output logic [ExtIdWidth-1:0]         acc_req_id_o,
  output logic [DataWidth-1:0]          acc_req_data_o,
  input  logic                          acc_rsp_valid_i,
  output logic                          acc_rsp_ready_o,
  input  logic [ExtIdWidth-1:0]         acc_rsp_id_i,
  input  logic [DataWidth-1:0]          acc_rsp_data_i,
  output logic [NumReq-1:0]             rsp_valid_o,
  input  logic [NumReq-1:0]             rsp_ready_i,
  output logic [IdWidth-1:0]            rsp_id_o,
  output logic [DataWidth-1:0]          rsp_data_o,
  output logic [NumReq*CntWidth-1:0]    outstanding_o,
  output logic                          err_o
);

  typedef logic [CntWidth-1:0] cnt_t;
  typedef logic [IdxWidth-1:0] idx_t;

  logic [NumReq-1:0][AddrWidth-1:0] addr_arr;
  logic [NumReq-1:0][IdWidth-1:0]   id_arr;
  logic [NumReq-1:0][DataWidth-1:0] data_arr;

  assign addr_arr = req_addr_i;
  assign id_arr   = req_id_i;
  assign data_arr = req_data_i;

  cnt_t [NumReq-1:0]     cnt_q, cnt_d;
  idx_t                  prio_q, prio_d;
  logic                  out_valid_q, out_valid_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [ExtIdWidth-1:0] id_q, id_d;
  logic [DataWidth-1:0]  data_q, data_d;
  logic                  err_q, err_d;

  logic [NumReq-1:0] elig;
  idx_t              gnt_idx;
  idx_t              cand;
  logic              gnt_vld;
  logic              load;
  logic              req_hs;
  idx_t              rsp_idx;
  logic              rsp_in_range;
  logic              rsp_cnt_zero;
  logic              rsp_bad;
  logic              rsp_hs;

  // Eligible: requesting and below the credit limit
  always_comb begin
    elig = '0;
    for (int r = 0; r < NumReq; r++) begin
      elig[r] = req_valid_i[r] &&
                (cnt_q[r] < cnt_t'(MaxOutstanding));
    end
  end

  // Round-robin search starting at prio_q
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = idx_t'((32'(prio_q) + i) % NumReq);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign load   = !out_valid_q || acc_req_ready_i;
  assign req_hs = gnt_vld && load && !rst_n;

  // Only the winner sees ready, and only when the register can load
  always_comb begin
    req_ready_o = '0;
    if (req_hs) req_ready_o[gnt_idx] = 1'b1;
  end

  // Output register, pointer advance and drain
  always_comb begin
    out_valid_d = out_valid_q;
    addr_d      = addr_q;
    id_d        = id_q;
    data_d      = data_q;
    prio_d      = prio_q;
    if (req_hs) begin
      out_valid_d = 1'b1;
      addr_d      = addr_arr[gnt_idx];
      id_d        = {gnt_idx, id_arr[gnt_idx]};
      data_d      = data_arr[gnt_idx];
      prio_d      = (gnt_idx == idx_t'(NumReq - 1)) ?
                    '0 : gnt_idx + idx_t'(1);
    end else if (acc_req_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  assign rsp_idx = acc_rsp_id_i[ExtIdWidth-1:IdWidth];

  // Route the response; unknown or uncredited IDs are dropped
  always_comb begin
    rsp_in_range    = 1'b0;
    rsp_cnt_zero    = 1'b1;
    rsp_valid_o     = '0;
    acc_rsp_ready_o = 1'b1;
    for (int r = 0; r < NumReq; r++) begin
      if (rsp_idx == idx_t'(r)) begin
        rsp_in_range = 1'b1;
        rsp_cnt_zero = (cnt_q[r] == '0);
      end
    end
    rsp_bad = !rsp_in_range || rsp_cnt_zero;
    if (!rsp_bad) begin
      for (int r = 0; r < NumReq; r++) begin
        if (rsp_idx == idx_t'(r)) begin
          rsp_valid_o[r]  = acc_rsp_valid_i;
          acc_rsp_ready_o = rsp_ready_i[r];
        end
      end
    end
    rsp_hs = acc_rsp_valid_i && !rsp_bad && acc_rsp_ready_o;
    err_d  = acc_rsp_valid_i && rsp_bad;
  end

  assign rsp_id_o   = acc_rsp_id_i[IdWidth-1:0];
  assign rsp_data_o = acc_rsp_data_i;

  // Credit counters: grant adds, good response removes
  always_comb begin
    cnt_d = cnt_q;
    for (int r = 0; r < NumReq; r++) begin
      if ((req_hs && gnt_idx == idx_t'(r)) &&
          !(rsp_hs && rsp_idx == idx_t'(r))) begin
        cnt_d[r] = cnt_q[r] + cnt_t'(1);
      end else if (!(req_hs && gnt_idx == idx_t'(r)) &&
                   (rsp_hs && rsp_idx == idx_t'(r))) begin
        cnt_d[r] = cnt_q[r] - cnt_t'(1);
      end
    end
  end

  // State registers, cleared by the active-high async reset
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      out_valid_q <= 1'b0;
      addr_q      <= '0;
      id_q        <= '0;
      data_q      <= '0;
      prio_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
      data_q      <= data_d;
      prio_q      <= prio_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign acc_req_valid_o = out_valid_q;
  assign acc_req_addr_o  = addr_q;
  assign acc_req_id_o    = id_q;
  assign acc_req_data_o  = data_q;
  assign outstanding_o   = cnt_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_acc_req_scheduler.sv
// Bench for acc_req_scheduler: reference model plus
// scoreboard queues drained by output monitors.
module tb_acc_req_scheduler;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int IW = 5;
  localparam int MO = 2;
  localparam int XW = 7;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [NR-1:0]          req_valid_i, req_ready_o;
  logic [NR-1:0][AW-1:0]  req_addr_i;
  logic [NR-1:0][IW-1:0]  req_id_i;
  logic [NR-1:0][DW-1:0]  req_data_i;
  logic                   acc_req_valid_o, acc_req_ready_i;
  logic [AW-1:0]          acc_req_addr_o;
  logic [XW-1:0]          acc_req_id_o;
  logic [DW-1:0]          acc_req_data_o;
  logic                   acc_rsp_valid_i, acc_rsp_ready_o;
  logic [XW-1:0]          acc_rsp_id_i;
  logic [DW-1:0]          acc_rsp_data_i;
  logic [NR-1:0]          rsp_valid_o, rsp_ready_i;
  logic [IW-1:0]          rsp_id_o;
  logic [DW-1:0]          rsp_data_o;
  logic [NR*CW-1:0]       outstanding_o;
  logic                   err_o;

  acc_req_scheduler #(
    .NumReq(NR), .DataWidth(DW), .AddrWidth(AW),
    .IdWidth(IW), .MaxOutstanding(MO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_id_i(req_id_i),
    .req_data_i(req_data_i),
    .acc_req_valid_o(acc_req_valid_o),
    .acc_req_ready_i(acc_req_ready_i),
    .acc_req_addr_o(acc_req_addr_o),
    .acc_req_id_o(acc_req_id_o),
    .acc_req_data_o(acc_req_data_o),
    .acc_rsp_valid_i(acc_rsp_valid_i),
    .acc_rsp_ready_o(acc_rsp_ready_o),
    .acc_rsp_id_i(acc_rsp_id_i),
    .acc_rsp_data_i(acc_rsp_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [XW-1:0] id;
    logic [DW-1:0] d;
  } areq_t;

  areq_t             aq[$];
  logic [IW+DW-1:0]  rq[$];
  logic [XW-1:0]     pend[$];

  int cnt[NR];
  int prio;
  bit occ;
  bit err_exp;
  int checks = 0;
  int errors = 0;

  logic [NR-1:0]         n_vld;
  logic [NR-1:0][AW-1:0] n_addr;
  logic [NR-1:0][IW-1:0] n_id;
  logic [NR-1:0][DW-1:0] n_data;
  logic                  n_ardy, n_rv;
  logic [XW-1:0]         n_rid;
  logic [DW-1:0]         n_rdata;
  logic [NR-1:0]         n_rrdy;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) cnt[r] = 0;
    prio = 0;
    occ = 1'b0;
    err_exp = 1'b0;
    aq.delete();
    rq.delete();
    pend.delete();
  endtask

  task automatic idle_next();
    n_vld = '0;
    n_ardy = 1'b1;
    n_rv = 1'b0;
    n_rid = '0;
    n_rdata = '0;
    n_rrdy = '1;
  endtask

  // One clock: apply inputs, check against model, advance model
  task automatic step();
    int g, r, ridx;
    bit load, bad0;
    logic [NR-1:0] er, ev;
    logic [NR*CW-1:0] eo;
    areq_t e;
    @(negedge clk);
    req_valid_i = n_vld;
    req_addr_i = n_addr;
    req_id_i = n_id;
    req_data_i = n_data;
    acc_req_ready_i = n_ardy;
    acc_rsp_valid_i = n_rv;
    acc_rsp_id_i = n_rid;
    acc_rsp_data_i = n_rdata;
    rsp_ready_i = n_rrdy;
    #1;
    g = -1;
    for (int i = 0; i < NR; i++) begin
      r = (prio + i) % NR;
      if (g < 0 && req_valid_i[r] && cnt[r] < MO) g = r;
    end
    load = !occ || acc_req_ready_i;
    er = '0;
    if (g >= 0 && load) er[g] = 1'b1;
    chk("req_ready", 64'(req_ready_o), 64'(er));
    chk("acc_req_valid", 64'(acc_req_valid_o), 64'(occ));
    for (int k = 0; k < NR; k++) eo[k*CW +: CW] = CW'(cnt[k]);
    chk("outstanding", 64'(outstanding_o), 64'(eo));
    chk("err", 64'(err_o), 64'(err_exp));
    ridx = int'(acc_rsp_id_i[XW-1:IW]);
    bad0 = (cnt[ridx] == 0);
    ev = '0;
    if (acc_rsp_valid_i && !bad0) ev[ridx] = 1'b1;
    chk("rsp_valid", 64'(rsp_valid_o), 64'(ev));
    if (acc_rsp_valid_i) begin
      chk("acc_rsp_ready", 64'(acc_rsp_ready_o),
          bad0 ? 64'd1 : 64'(rsp_ready_i[ridx]));
      if (!bad0) rq.push_back({acc_rsp_id_i[IW-1:0], acc_rsp_data_i});
    end
    if (acc_rsp_valid_i && !bad0 && rsp_ready_i[ridx]) begin
      cnt[ridx]--;
      for (int k = 0; k < pend.size(); k++) begin
        if (pend[k] == acc_rsp_id_i) begin
          pend.delete(k);
          break;
        end
      end
    end
    if (g >= 0 && load) begin
      e.a = req_addr_i[g];
      e.id = {2'(g), req_id_i[g]};
      e.d = req_data_i[g];
      aq.push_back(e);
      cnt[g]++;
      prio = (g + 1) % NR;
      occ = 1'b1;
    end else if (acc_req_ready_i) begin
      occ = 1'b0;
    end
    err_exp = acc_rsp_valid_i && bad0;
  endtask

  task automatic rand_next();
    int sel;
    int zr[$];
    n_vld = NR'($urandom);
    for (int r = 0; r < NR; r++) begin
      n_addr[r] = AW'($urandom);
      n_id[r] = IW'($urandom);
      n_data[r] = $urandom;
    end
    n_ardy = ($urandom % 4) != 0;
    n_rrdy = NR'($urandom | $urandom);
    n_rdata = $urandom;
    n_rv = 1'b0;
    n_rid = XW'($urandom);
    sel = int'($urandom % 10);
    if (sel < 4 && pend.size() > 0) begin
      n_rid = pend[$urandom % pend.size()];
      n_rv = 1'b1;
    end else if (sel == 9) begin
      for (int r = 0; r < NR; r++) if (cnt[r] == 0) zr.push_back(r);
      if (zr.size() > 0) begin
        n_rv = 1'b1;
        n_rid = {2'(zr[$urandom % zr.size()]), IW'($urandom)};
      end
    end
  endtask

  // Request monitor: compare held/drained output with queue head
  always @(negedge clk) begin
    #2;
    if (acc_req_valid_o === 1'b1) begin
      if (aq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL acc_req_unexpected: got id %0h expected none",
                 acc_req_id_o);
      end else begin
        chk("acc_req", 64'({acc_req_addr_o, acc_req_id_o,
                            acc_req_data_o}), 64'(aq[0]));
        if (acc_req_ready_i) begin
          pend.push_back(aq[0].id);
          void'(aq.pop_front());
        end
      end
    end
  end

  // Response monitor: every presented response matches the queue
  always @(negedge clk) begin
    #3;
    if (|rsp_valid_o) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0h expected none",
                 rsp_id_o);
      end else begin
        chk("rsp_payload", 64'({rsp_id_o, rsp_data_o}), 64'(rq[0]));
        void'(rq.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    req_valid_i = '0;
    req_addr_i = '0;
    req_id_i = '0;
    req_data_i = '0;
    acc_req_ready_i = 1'b0;
    acc_rsp_valid_i = 1'b0;
    acc_rsp_id_i = '0;
    acc_rsp_data_i = '0;
    rsp_ready_i = '0;
    n_addr = '0;
    n_id = '0;
    n_data = '0;
    idle_next();
    model_reset();
    req_valid_i = '1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready_o), 64'd0);
    chk("rst_acc_valid", 64'(acc_req_valid_o), 64'd0);
    chk("rst_acc_id", 64'(acc_req_id_o), 64'd0);
    chk("rst_acc_data", 64'(acc_req_data_o), 64'd0);
    chk("rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    req_valid_i = '0;
    @(negedge clk);
    rst_n = 1'b0;

    // single request from requester 2
    idle_next();
    n_vld = 4'b0100;
    n_addr[2] = 4'd3;
    n_id[2] = 5'd5;
    n_data[2] = 32'hDEADBEEF;
    step();
    idle_next();
    step();
    chk("single_id", 64'(acc_req_id_o), 64'h45);
    chk("single_addr", 64'(acc_req_addr_o), 64'd3);
    chk("single_data", 64'(acc_req_data_o), 64'hDEADBEEF);
    chk("single_cnt2", 64'(outstanding_o[2*CW +: CW]), 64'd1);

    // all requesters busy, ready high
    for (int r = 0; r < NR; r++) begin
      n_addr[r] = AW'(r);
      n_id[r] = 5'd5;
      n_data[r] = 32'h100 + r;
    end
    n_vld = '1;
    repeat (6) step();

    // backpressure with a pending output
    n_ardy = 1'b0;
    repeat (3) step();
    n_ardy = 1'b1;
    step();
    n_vld = '0;
    step();

    // routed response stalled, then accepted
    n_rv = 1'b1;
    n_rid = 7'h65;
    n_rdata = 32'hCAFE0003;
    n_rrdy = 4'b0111;
    step();
    n_rrdy = 4'b1111;
    step();
    idle_next();
    step();

    // randomized traffic
    repeat (1500) begin
      rand_next();
      step();
    end

    // reset with a request held in the output register
    idle_next();
    n_vld = '1;
    n_ardy = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    req_valid_i = '0;
    acc_rsp_valid_i = 1'b0;
    #1;
    chk("mid_rst_acc_valid", 64'(acc_req_valid_o), 64'd0);
    chk("mid_rst_outstanding", 64'(outstanding_o), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready_o), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b0;

    // zero-credit response dropped, err pulse
    idle_next();
    n_rv = 1'b1;
    n_rid = 7'h25;
    n_rrdy = 4'b0000;
    step();
    chk("drop_ready", 64'(acc_rsp_ready_o), 64'd1);
    idle_next();
    step();
    chk("err_pulse", 64'(err_o), 64'd1);

    // first grant after reset goes to requester 0
    n_vld = '1;
    step();
    chk("post_rst_grant", 64'(req_ready_o), 64'b0001);
    repeat (200) begin
      rand_next();
      step();
    end
    idle_next();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_req_scheduler.md
# acc_req_scheduler

Shares one accelerator request/response port between `NumReq` offloading requesters (cores) on a single interconnect level. Arbitrates round-robin, registers the winning request, and extends its ID with the requester index. It also limits outstanding transactions per requester with credit counters and routes responses back by the index field of the extended ID. It sits between the requester-side ACC bus ports and one accelerator slave port.

## Interface
- `NumReq`, 4: number of requesters, ≥1.
- `DataWidth`, 32: operand/result width.
- `AddrWidth`, 4: accelerator address width, passed through unchanged.
- `IdWidth`, 5: requester-side ID width.
- `MaxOutstanding`, 4: per-requester limit of issued-but-unanswered requests, ≥1.
- Derived: `IdxWidth = max(1, $clog2(NumReq))`, `ExtIdWidth = IdWidth + IdxWidth`, `CntWidth = $clog2(MaxOutstanding+1)`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-high.
- `req_valid_i` in `NumReq`: per-requester request valid.
- `req_ready_o` out `NumReq`: per-requester request ready.
- `req_addr_i` in `NumReq*AddrWidth`: packed addresses; requester r uses slice r.
- `req_id_i` in `NumReq*IdWidth`: packed IDs.
- `req_data_i` in `NumReq*DataWidth`: packed operands.
- `acc_req_valid_o` out 1 / `acc_req_ready_i` in 1: downstream request handshake.
- `acc_req_addr_o` out `AddrWidth`, `acc_req_id_o` out `ExtIdWidth`, `acc_req_data_o` out `DataWidth`: registered request.
- `acc_rsp_valid_i` in 1 / `acc_rsp_ready_o` out 1: downstream response handshake.
- `acc_rsp_id_i` in `ExtIdWidth`, `acc_rsp_data_i` in `DataWidth`: response from the accelerator.
- `rsp_valid_o` out `NumReq` / `rsp_ready_i` in `NumReq`: per-requester response handshake.
- `rsp_id_o` out `IdWidth`, `rsp_data_o` out `DataWidth`: broadcast to all requesters; qualified by `rsp_valid_o`.
- `outstanding_o` out `NumReq*CntWidth`: credit counters.
- `err_o` out 1: one-cycle pulse on a bad response.

## Operation
- **Eligibility.** Requester r is eligible when `req_valid_i[r]` is high and `cnt[r] < MaxOutstanding`.
- **Load condition.** `load = !out_valid || acc_req_ready_i`. The output register is either empty or being drained this cycle.
- **Arbitration.** Round-robin over eligible requesters. Search starts at pointer `prio`. Winner g gets `req_ready_o[g] = load`; all other `req_ready_o` bits are 0.
- **On request handshake with g:**
  - Output register loads `{addr[g], {g, id[g]}, data[g]}`; the extended ID is {index in MSBs, original ID in LSBs}.
  - `out_valid` is set.
  - `prio` becomes `(g+1) mod NumReq`.
  - `cnt[g]` increments.
- **Draining.** On `acc_req_valid_o && acc_req_ready_i` with no new load, `out_valid` clears.
- **Stability.** While `acc_req_valid_o` is high and `acc_req_ready_i` is low, the output register and `prio` hold.
- **Response routing (combinational).**
  - `idx = acc_rsp_id_i[ExtIdWidth-1:IdWidth]`.
  - `rsp_valid_o[idx] = acc_rsp_valid_i`, `acc_rsp_ready_o = rsp_ready_i[idx]`.
  - `rsp_id_o` is the low `IdWidth` bits of `acc_rsp_id_i`; `rsp_data_o = acc_rsp_data_i`.
- **Bad response.** If `idx ≥ NumReq` or `cnt[idx] == 0`, the response is bad:
  - `acc_rsp_ready_o = 1` (dropped), all `rsp_valid_o` = 0.
  - `err_o` pulses the following cycle.
  - No counter changes.
- **Good response handshake.** `cnt[idx]` decrements.
- **Simultaneous increment and decrement** on the same counter: the value is unchanged.

## Timing
- **Reset values.** `out_valid`=0, `acc_req_*` data outputs=0, `prio`=0, all `cnt`=0, `err_o`=0. `req_ready_o` is 0 for all bits during reset.
- **Request latency.** A request accepted in cycle N appears on `acc_req_valid_o` in N+1.
- **Request throughput.** One request per cycle with `acc_req_ready_i` held high.
- **Response latency.** 0 cycles, pure combinational path.
- **Credit release.** A response handshake in cycle N makes that requester eligible again in N+1, not in N.
- **`NumReq==1`.** Index field is 1 bit and always 0; an index value of 1 is bad.
- **Reset mid-operation.** A held output request is discarded, all counters clear, and the next grant starts at requester 0.

## Test plan
- **Single request.** `NumReq=4`. Requester 2 sends addr 3, id 5, data 0xDEADBEEF; `acc_req_ready_i`=1. Required: one cycle later `acc_req_valid_o`=1, id 0x45, addr 3, data 0xDEADBEEF; `outstanding` of requester 2 = 1.
- **Round-robin fairness.** All four requesters valid continuously, ready held high. Required: grants 0,1,2,3,0,1… one per cycle; no requester waits more than 3 cycles.
- **Backpressure.** `acc_req_ready_i` held low for 3 cycles with an output pending. Required: `acc_req_*` stable, all `req_ready_o`=0, `prio` frozen; the pending request drains and the next grant happens in the same cycle ready rises.
- **Credit limit.** `MaxOutstanding=2`. Requester 1 issues 2 requests; a third is held with `req_ready_o[1]`=0 while requester 0 continues to be granted. Response id 0x25 is accepted. Required: requester 1 is granted in the next cycle.
- **Response routing.** Response id 0x65 with `rsp_ready_i[3]`=0. Required: `rsp_valid_o`=4'b1000, `rsp_id_o`=5, `acc_rsp_ready_o`=0; the handshake completes when `rsp_ready_i[3]` rises. A response to a requester with a zero counter is dropped and `err_o` pulses for one cycle.
- **Reset mid-operation.** Assert `rst_n` while requests are pending. Required: all outputs return to reset values immediately; after release, the first grant goes to requester 0.
